// File: rtl/conv1_pkg.sv
// conv1_pkg: shared image geometry, window shape and pixel/window types for conv1
package conv1_pkg;
    localparam int DATA_W   = 32;
    localparam int IMG_W    = 28;
    localparam int IMG_H    = 28;
    localparam int WIN_SIZE = 3;
    localparam int WIN_TAPS = WIN_SIZE * WIN_SIZE;
    typedef logic [DATA_W-1:0] pix_t;
    typedef pix_t win_t [0:WIN_TAPS-1];
endpackage

// File: rtl/conv1_line_buf.sv
// conv1_line_buf: enabled delay line of DEPTH words; storage has no reset
// ports: clk, en_i (shift enable), din_i (word in), dout_o (word from DEPTH enables ago)
module conv1_line_buf
    import conv1_pkg::*;
#(
    parameter int DEPTH = IMG_W,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    logic [WIDTH-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
        end
    end

    assign dout_o = mem_q[DEPTH-1];
endmodule

// File: rtl/conv1_window_buf.sv
// conv1_window_buf: raster pixel stream to 3x3 valid-padded sliding windows
// ports: clk, rst_n (async active-low), valid_in/data_in (pixel stream),
//        data_out[0:8] (row-major window), valid_out (window strobe), frame_done (last window)
module conv1_window_buf
    import conv1_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic valid_in,
    input  pix_t data_in,
    output win_t data_out,
    output logic valid_out,
    output logic frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          valid_q, valid_d, done_q, done_d;
    logic          last_col, last_row;
    pix_t          tap0, tap1;
    win_t          win_q, win_d;

    conv1_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
        .clk(clk), .en_i(valid_in), .din_i(data_in), .dout_o(tap0)
    );

    conv1_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
        .clk(clk), .en_i(valid_in), .din_i(tap0), .dout_o(tap1)
    );

    assign last_col = col_q == CW'(IMG_W - 1);
    assign last_row = row_q == RW'(IMG_H - 1);

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        // a window is complete only once two full rows and two columns of this row are in
        valid_d = valid_in && row_q >= RW'(2) && col_q >= CW'(2);
        done_d  = valid_in && last_row && last_col;
        if (valid_in) begin
            col_d = last_col ? '0 : col_q + 1'b1;
            if (last_col) row_d = last_row ? '0 : row_q + 1'b1;
            for (int r = 0; r < WIN_SIZE; r++) begin
                win_d[WIN_SIZE*r]   = win_q[WIN_SIZE*r+1];
                win_d[WIN_SIZE*r+1] = win_q[WIN_SIZE*r+2];
            end
            win_d[2] = tap1;
            win_d[5] = tap0;
            win_d[8] = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < WIN_TAPS; k++) win_q[k] <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    assign data_out   = win_q;
    assign valid_out  = valid_q;
    assign frame_done = done_q;
endmodule
